// File: rtl/mem_pkg.sv
// Shared definitions for the RAM port arbiter: lock-state encoding,
// master indices and default widths.
package mem_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED_0 = 2'd1,
    LOCKED_1 = 2'd2
  } lock_state_e;

  localparam int M_FETCH = 0;
  localparam int M_DATA  = 1;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_ADDR_SPACE   = 16;
  localparam int DEF_LOCK_TIMEOUT = 15;

  // Masters allowed to compete in a given lock state.
  function automatic logic [1:0] eligible_mask(lock_state_e s);
    logic [1:0] m;
    m = 2'b11;
    case (s)
      LOCKED_0: m = 2'b01;
      LOCKED_1: m = 2'b10;
      default:  m = 2'b11;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the master that did not
// win last time is granted.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (&req_i) begin
      gnt_o = 2'b00;
      gnt_o[rr_last_i ? M_FETCH : M_DATA] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Fetch/data arbiter in front of the single-port RAM with bus lock,
// lock timeout and one-cycle registered read responses.
module ram_port_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_SPACE   = DEF_ADDR_SPACE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [ADDR_SPACE-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [ADDR_SPACE-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_SPACE-1:0] ram_address,
  output logic [DATA_WIDTH:0]   ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TMO = CW'(LOCK_TIMEOUT);

  lock_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic rr_last_q;
  logic [1:0] rvalid_q;
  logic [1:0][DATA_WIDTH-1:0] rdata_q;

  logic [1:0] valid, we, lock, req, gnt;
  logic owner;

  assign valid = {m1_valid, m0_valid};
  assign we    = {m1_we, m0_we};
  assign lock  = {m1_lock, m0_lock};

  // Grants are suppressed while reset is held so no write leaks through.
  assign req = valid & eligible_mask(state_q) & {2{reset_n}};

  rr_arbiter2 u_rr (
    .req_i     (req),
    .rr_last_i (rr_last_q),
    .gnt_o     (gnt)
  );

  assign m0_ready  = gnt[M_FETCH];
  assign m1_ready  = gnt[M_DATA];
  assign m0_rvalid = rvalid_q[M_FETCH];
  assign m1_rvalid = rvalid_q[M_DATA];
  assign m0_rdata  = rdata_q[M_FETCH];
  assign m1_rdata  = rdata_q[M_DATA];

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    unique case (1'b1)
      gnt[M_FETCH]: begin
        ram_address = m0_addr;
        ram_data    = {1'b0, m0_wdata};
        ram_wren    = m0_we;
      end
      gnt[M_DATA]: begin
        ram_address = m1_addr;
        ram_data    = {1'b0, m1_wdata};
        ram_wren    = m1_we;
      end
      default: ;
    endcase
  end

  assign owner   = (state_q == LOCKED_1);
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      UNLOCKED: begin
        cnt_d = '0;
        if (gnt[M_FETCH] && m0_lock) begin
          state_d = LOCKED_0;
        end else if (gnt[M_DATA] && m1_lock) begin
          state_d = LOCKED_1;
        end
      end
      LOCKED_0, LOCKED_1: begin
        if (gnt[owner]) begin
          cnt_d = '0;
          if (!lock[owner]) state_d = UNLOCKED;
        end else if (valid[owner]) begin
          cnt_d = '0;
        end else if (cnt_inc == CNT_TMO) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= UNLOCKED;
      cnt_q     <= '0;
      rr_last_q <= 1'b1;
      rvalid_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt & ~we;
      if (|gnt) rr_last_q <= gnt[M_DATA];
      for (int i = 0; i < 2; i++) begin
        if (gnt[i] && !we[i]) rdata_q[i] <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus
// random traffic against a transaction-level reference model.
module tb_ram_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int LT = 15;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic m0_valid, m0_ready, m0_we, m0_lock, m0_rvalid;
  logic m1_valid, m1_ready, m1_we, m1_lock, m1_rvalid;
  logic [AW-1:0] m0_addr, m1_addr, ram_address;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_q;
  logic [DW:0] ram_data;
  logic ram_wren;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  int owner;
  int idle;
  int last;
  logic [1:0] exp_rvalid;
  logic [DW-1:0] exp_rdata [2];

  always #5 clock = ~clock;

  assign ram_q = ram[ram_address];
  always @(posedge clock) if (ram_wren) ram[ram_address] <= ram_data[DW-1:0];

  ram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_SPACE(AW), .LOCK_TIMEOUT(LT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we),
    .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we),
    .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    idle = 0;
    last = 1;
    exp_rvalid = 2'b00;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
  endtask

  task automatic drive(input bit v0, input bit we0, input bit lk0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input bit we1, input bit lk1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_valid = v0; m0_we = we0; m0_lock = lk0; m0_addr = a0; m0_wdata = d0;
    m1_valid = v1; m1_we = we1; m1_lock = lk1; m1_addr = a1; m1_wdata = d1;
  endtask

  // One clock: check the combinational grant/RAM pins, then the
  // registered response after the edge, then advance the model.
  task automatic step(output logic [1:0] rdy);
    int g;
    bit r0, r1, gwe, glk, vo;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    #2;
    r0 = m0_valid && owner != 1;
    r1 = m1_valid && owner != 0;
    if (!reset_n) g = -1;
    else if (r0 && r1) g = (last == 1) ? 0 : 1;
    else if (r0) g = 0;
    else if (r1) g = 1;
    else g = -1;
    ga  = (g == 1) ? m1_addr  : m0_addr;
    gd  = (g == 1) ? m1_wdata : m0_wdata;
    gwe = (g == 1) ? m1_we    : m0_we;
    glk = (g == 1) ? m1_lock  : m0_lock;
    vo  = (owner == 0) ? m0_valid : (owner == 1) ? m1_valid : 1'b0;
    rdy = {m1_ready, m0_ready};
    chk("m0_ready", m0_ready, g == 0);
    chk("m1_ready", m1_ready, g == 1);
    chk("ram_wren", ram_wren, g >= 0 && gwe);
    chk("ram_address", ram_address, (g >= 0) ? ga : '0);
    chk("ram_data", ram_data, (g >= 0) ? {1'b0, gd} : 17'h0);
    @(posedge clock);
    #1;
    if (!reset_n) begin
      model_reset();
    end else begin
      exp_rvalid = 2'b00;
      if (g >= 0 && !gwe) begin
        exp_rvalid[g] = 1'b1;
        exp_rdata[g] = ref_mem[ga];
      end
      if (g >= 0 && gwe) ref_mem[ga] = gd;
      if (owner < 0) begin
        if (g >= 0 && glk) begin owner = g; idle = 0; end
      end else if (g == owner) begin
        idle = 0;
        if (!glk) owner = -1;
      end else if (vo) begin
        idle = 0;
      end else begin
        idle++;
        if (idle == LT) begin owner = -1; idle = 0; end
      end
      if (g >= 0) last = g;
    end
    chk("m0_rvalid", m0_rvalid, exp_rvalid[0]);
    chk("m1_rvalid", m1_rvalid, exp_rvalid[1]);
    chk("m0_rdata", m0_rdata, exp_rdata[0]);
    chk("m1_rdata", m1_rdata, exp_rdata[1]);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0] rdy;
    int n;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] <= 16'(i * 37 + 5);
      ref_mem[i] = 16'(i * 37 + 5);
    end
    ram[16'h0010] <= 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_ready", {m1_ready, m0_ready}, 0);
    reset_n = 1'b1;

    // first read after reset
    drive(1, 0, 0, 16'h0010, '0, 0, 0, 0, '0, '0);
    step(rdy);
    chk("t1_ready", rdy, 2'b01);
    chk("t1_rdata", m0_rdata, 16'hBEEF);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    drive(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    step(rdy);

    // continuous contention alternates starting with m0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 16'(i), '0, 1, 0, 0, 16'(100 + i), '0);
      step(rdy);
      chk("t2_alt", rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // write then read-back on consecutive cycles
    drive(0, 0, 0, '0, '0, 1, 1, 0, 16'h00FF, 16'h1234);
    step(rdy);
    drive(0, 0, 0, '0, '0, 1, 0, 0, 16'h00FF, '0);
    step(rdy);
    chk("t3_rdata", m1_rdata, 16'h1234);

    // m1 lock held across an idle cycle while m0 waits
    drive(1, 0, 0, 16'h0020, '0, 0, 0, 0, '0, '0);
    step(rdy);
    drive(1, 0, 0, 16'h0021, '0, 1, 0, 1, 16'h0030, '0);
    step(rdy);
    chk("t4_lock", rdy, 2'b10);
    drive(1, 0, 0, 16'h0021, '0, 0, 0, 0, '0, '0);
    step(rdy);
    chk("t4_blocked", rdy, 2'b00);
    drive(1, 0, 0, 16'h0021, '0, 1, 1, 0, 16'h0030, 16'hA5A5);
    step(rdy);
    chk("t4_unlock", rdy, 2'b10);
    drive(1, 0, 0, 16'h0021, '0, 0, 0, 0, '0, '0);
    step(rdy);
    chk("t4_m0_after", rdy, 2'b01);

    // lock timeout
    drive(1, 0, 1, 16'h0040, '0, 0, 0, 0, '0, '0);
    step(rdy);
    chk("t5_take", rdy, 2'b01);
    drive(0, 0, 0, '0, '0, 1, 0, 0, 16'h0041, '0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(rdy);
      if (rdy[1]) break;
      n++;
    end
    chk("t5_timeout", n, LT);

    // reset during a granted read with m1 holding the lock
    drive(0, 0, 0, '0, '0, 1, 0, 1, 16'h0050, '0);
    step(rdy);
    reset_n = 1'b0;
    drive(1, 0, 0, 16'h0010, '0, 0, 0, 0, '0, '0);
    step(rdy);
    chk("t6_no_rvalid", m0_rvalid, 0);
    reset_n = 1'b1;
    drive(1, 0, 0, 16'h0011, '0, 1, 0, 0, 16'h0012, '0);
    step(rdy);
    chk("t6_first", rdy, 2'b01);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
            16'($urandom_range(0, 15)), 16'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
            16'($urandom_range(0, 15)), 16'($urandom));
      step(rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
